// File: rtl/axis_sum_pkg.sv
// Shared types and constants for the packet-sum collector.
package axis_sum_pkg;

  // Collector state: assemble bytes, present the word, or discard an over-long tail.
  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    HOLD    = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  localparam int BYTES_PER_WORD_DEF = 4;
  localparam int SUM_W              = 32;

endpackage

// File: rtl/axis_sum_collector_if.sv
// Byte-stream input and word-stream output of the collector, bundled as one interface.
interface axis_sum_collector_if;
  import axis_sum_pkg::*;

  logic [7:0]       TDATA_in;
  logic             TLAST_in;
  logic             TVALID_in;
  logic             TREADY_out;
  logic [SUM_W-1:0] WDATA_out;
  logic             WERR_out;
  logic             WVALID_out;
  logic             WREADY_in;

  // Collector side: consumes bytes, produces words.
  modport slave (
    input  TDATA_in, TLAST_in, TVALID_in, WREADY_in,
    output TREADY_out, WDATA_out, WERR_out, WVALID_out
  );

  // Environment side: produces bytes, consumes words.
  modport master (
    output TDATA_in, TLAST_in, TVALID_in, WREADY_in,
    input  TREADY_out, WDATA_out, WERR_out, WVALID_out
  );
endinterface

// File: rtl/axis_sum_collector_sat_counter.sv
// Saturating up-counter with asynchronous clear; sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count
);

  // Count enabled events, holding at the maximum instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/axis_sum_collector.sv
// Collects big-endian byte frames into one word, flags framing errors,
// and keeps saturating frame/error counters.
module axis_sum_collector
  import axis_sum_pkg::*;
#(
  parameter int BYTES_PER_WORD = BYTES_PER_WORD_DEF,
  parameter int CNT_W          = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  axis_sum_collector_if.slave   bus,
  output logic [CNT_W-1:0]      frame_count,
  output logic [CNT_W-1:0]      err_count
);

  localparam int IDX_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [SUM_W-1:0] word;
  logic             err;
  logic             drain;
  logic             ready_en;

  logic             accept;
  logic             xfer;
  logic             err_xfer;

  assign bus.TREADY_out = ready_en & (state != HOLD);
  assign bus.WVALID_out = (state == HOLD);
  assign bus.WDATA_out  = word;
  assign bus.WERR_out   = err;

  assign accept   = bus.TVALID_in & bus.TREADY_out;
  assign xfer     = bus.WVALID_out & bus.WREADY_in;
  assign err_xfer = xfer & err;

  // Frame assembly FSM; ready_en keeps the input closed for one cycle after reset.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state    <= COLLECT;
      idx      <= '0;
      word     <= '0;
      err      <= 1'b0;
      drain    <= 1'b0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      case (state)
        COLLECT: begin
          if (accept) begin
            word <= {word[SUM_W-9:0], bus.TDATA_in};
            idx  <= idx + 1'b1;
            if (bus.TLAST_in) begin
              // Short frames leave the word right-aligned with zero upper bytes.
              state <= HOLD;
              err   <= (idx != LAST_IDX);
              drain <= 1'b0;
            end else if (idx == LAST_IDX) begin
              // Over-long frame: present what we have, then swallow the tail.
              state <= HOLD;
              err   <= 1'b1;
              drain <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (xfer) begin
            state <= drain ? DRAIN : COLLECT;
            word  <= '0;
            idx   <= '0;
            err   <= 1'b0;
          end
        end
        DRAIN: begin
          if (accept && bus.TLAST_in) begin
            state <= COLLECT;
            idx   <= '0;
          end
        end
        default: begin
          state <= COLLECT;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_frame_cnt (
    .clk   (ACLK),
    .rst   (ARESET),
    .en    (xfer),
    .count (frame_count)
  );

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk   (ACLK),
    .rst   (ARESET),
    .en    (err_xfer),
    .count (err_count)
  );

endmodule

// File: tb/tb_axis_sum_collector.sv
// Directed bench for axis_sum_collector with an expected/observed word scoreboard.
module tb_axis_sum_collector;
  import axis_sum_pkg::*;

  localparam int LIMIT = 64;

  logic        ACLK;
  logic        ARESET;
  logic [15:0] frame_count;
  logic [15:0] err_count;
  logic [1:0]  frame_count_s;
  logic [1:0]  err_count_s;

  int total = 0;
  int bad   = 0;

  logic [32:0] exp_q[$];
  logic [32:0] obs_q[$];

  axis_sum_collector_if bus ();
  axis_sum_collector_if bus_s ();

  // Second instance sees identical stimulus but has 2-bit counters.
  assign bus_s.TDATA_in  = bus.TDATA_in;
  assign bus_s.TLAST_in  = bus.TLAST_in;
  assign bus_s.TVALID_in = bus.TVALID_in;
  assign bus_s.WREADY_in = bus.WREADY_in;

  axis_sum_collector #(.BYTES_PER_WORD(4), .CNT_W(16)) dut (
    .ACLK        (ACLK),
    .ARESET      (ARESET),
    .bus         (bus),
    .frame_count (frame_count),
    .err_count   (err_count)
  );

  axis_sum_collector #(.BYTES_PER_WORD(4), .CNT_W(2)) dut_s (
    .ACLK        (ACLK),
    .ARESET      (ARESET),
    .bus         (bus_s),
    .frame_count (frame_count_s),
    .err_count   (err_count_s)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // Record each word the sink accepts; the transfer completes on the next rising edge.
  always @(negedge ACLK) begin
    if (!ARESET && bus.WVALID_out && bus.WREADY_in)
      obs_q.push_back({bus.WERR_out, bus.WDATA_out});
  end

  task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    int cnt;
    cnt = 0;
    bus.TDATA_in  = d;
    bus.TLAST_in  = l;
    bus.TVALID_in = 1'b1;
    while (!bus.TREADY_out && cnt < LIMIT) begin
      @(negedge ACLK);
      cnt++;
    end
    if (cnt >= LIMIT) begin
      total++;
      bad++;
      $error("FAIL tready_timeout observed=%0d expected<%0d", cnt, LIMIT);
    end
    @(posedge ACLK);
    #1;
    bus.TVALID_in = 1'b0;
    bus.TLAST_in  = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic l);
    send_byte(w[31:24], 1'b0);
    send_byte(w[23:16], 1'b0);
    send_byte(w[15:8],  1'b0);
    send_byte(w[7:0],   l);
  endtask

  task automatic wait_out(input string tag);
    int cnt;
    logic [32:0] e;
    logic [32:0] o;
    cnt = 0;
    while (obs_q.size() == 0 && cnt < LIMIT) begin
      @(posedge ACLK);
      #2;
      cnt++;
    end
    if (obs_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s_timeout observed=none expected=word", tag);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end else begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      chk({tag, "_data"}, 64'(o[31:0]), 64'(e[31:0]));
      chk({tag, "_err"},  64'(o[32]),   64'(e[32]));
    end
  endtask

  initial begin
    ARESET        = 1'b1;
    bus.TDATA_in  = 8'h00;
    bus.TLAST_in  = 1'b0;
    bus.TVALID_in = 1'b0;
    bus.WREADY_in = 1'b1;

    // Reset state
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    chk("rst_tready", 64'(bus.TREADY_out), 64'd0);
    chk("rst_wvalid", 64'(bus.WVALID_out), 64'd0);
    chk("rst_wdata",  64'(bus.WDATA_out),  64'd0);
    chk("rst_werr",   64'(bus.WERR_out),   64'd0);
    chk("rst_counts", {32'(frame_count), 32'(err_count)}, 64'd0);
    @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    @(negedge ACLK);
    chk("rel_tready_first", 64'(bus.TREADY_out), 64'd0);
    @(negedge ACLK);
    chk("rel_tready_second", 64'(bus.TREADY_out), 64'd1);

    // Good frame, plus one-cycle latency to WVALID_out
    exp_q.push_back({1'b0, 32'h12345678});
    send_word(32'h12345678, 1'b1);
    chk("good_wvalid_latency", 64'(bus.WVALID_out), 64'd1);
    chk("good_wdata_early", 64'(bus.WDATA_out), 64'h12345678);
    wait_out("good");
    chk("good_frame_count", 64'(frame_count), 64'd1);
    chk("good_err_count", 64'(err_count), 64'd0);

    // Short frame
    exp_q.push_back({1'b1, 32'h0000ABCD});
    send_byte(8'hAB, 1'b0);
    send_byte(8'hCD, 1'b1);
    wait_out("short");
    chk("short_counts", {32'(frame_count), 32'(err_count)}, {32'd2, 32'd1});

    // Long frame, then a good frame immediately after the draining TLAST
    exp_q.push_back({1'b1, 32'h01020304});
    exp_q.push_back({1'b0, 32'hCAFEBABE});
    for (int i = 1; i <= 6; i++) send_byte(8'(i), (i == 6));
    send_word(32'hCAFEBABE, 1'b1);
    wait_out("long");
    wait_out("after_long");
    chk("long_counts", {32'(frame_count), 32'(err_count)}, {32'd4, 32'd2});

    // One-byte frame
    exp_q.push_back({1'b1, 32'h000000EE});
    send_byte(8'hEE, 1'b1);
    wait_out("one_byte");
    chk("one_byte_counts", {32'(frame_count), 32'(err_count)}, {32'd5, 32'd3});

    // Output backpressure held for 10 cycles in HOLD
    bus.WREADY_in = 1'b0;
    exp_q.push_back({1'b0, 32'hDEADBEEF});
    send_word(32'hDEADBEEF, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge ACLK);
      chk("stall_hold",
          {bus.WDATA_out, 14'd0, bus.TREADY_out, bus.WVALID_out, frame_count},
          {32'hDEADBEEF, 14'd0, 1'b0, 1'b1, 16'd5});
    end
    bus.WREADY_in = 1'b1;
    wait_out("stall");
    chk("stall_frame_count", 64'(frame_count), 64'd6);

    // Reset in the middle of a frame
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    ARESET = 1'b1;
    @(negedge ACLK);
    chk("midrst_state",
        {32'(frame_count), 16'(err_count), 14'd0, bus.WVALID_out, bus.TREADY_out},
        64'd0);
    @(posedge ACLK);
    #1;
    ARESET = 1'b0;

    // Five good frames after reset: no residue, and 2-bit counter saturates
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back({1'b0, 32'hA1B2C3D4 + 32'(i)});
      send_word(32'hA1B2C3D4 + 32'(i), 1'b1);
      wait_out("post_rst");
    end
    chk("post_rst_frame_count", 64'(frame_count), 64'd5);
    chk("post_rst_err_count", 64'(err_count), 64'd0);
    chk("sat_frame_count", 64'(frame_count_s), 64'd3);
    chk("sat_err_count", 64'(err_count_s), 64'd0);
    chk("obs_leftover", 64'(obs_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
